// File: rtl/srl_shift_fifo.sv
// Shift-register FIFO whose storage maps onto SRL16/SRL32 primitives.
// Latency: a word pushed at edge N is presented on out_data after edge N; no fall-through path.
// Backpressure: in_ready = !full, out_valid = !empty, both decoded from the registered fill count.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; clears fill count and afull
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept a word this cycle
//   in_data    write data
//   out_valid  FIFO holds at least one word
//   out_ready  consumer takes out_data this cycle
//   out_data   oldest stored word (combinational mux, don't-care when empty)
//   used       fill level 0..2**DEPTH_LOG2
//   afull      registered flag, used >= AFULL_LEVEL
module srl_shift_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = (2 ** DEPTH_LOG2) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   used,
  output logic                  afull
);

  localparam int                D        = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(D);
  localparam logic [DEPTH_LOG2:0] CNT_AF   = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  // No reset on the storage so it can pack into shift-register primitives.
  logic [WIDTH-1:0]        mem [D];
  logic [DEPTH_LOG2:0]     used_q;
  logic [DEPTH_LOG2:0]     used_d;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic                    push;
  logic                    pop;
  logic                    afull_q;

  // Handshakes depend only on the registered count, so there is no
  // combinational path from in_valid/out_ready to the ready/valid outputs.
  assign in_ready  = (used_q != CNT_FULL);
  assign out_valid = (used_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The oldest word sits at position used-1. On a simultaneous push/pop the
  // shift moves every word up by one while the address stays put, so the
  // oldest word falls off the read point and the next-oldest takes its place.
  assign rd_addr  = used_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
  assign out_data = mem[rd_addr];
  assign used     = used_q;
  assign afull    = afull_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[0] <= in_data;
      for (int i = 1; i < D; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Push is blocked when full and pop is blocked when empty, so the counter
  // can never overflow or underflow.
  always_comb begin
    used_d = used_q;
    case ({push, pop})
      2'b10:   used_d = used_q + CNT_ONE;
      2'b01:   used_d = used_q - CNT_ONE;
      default: used_d = used_q;
    endcase
  end

  // afull is registered from the next-state count so it lines up with used.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q  <= '0;
      afull_q <= 1'b0;
    end else begin
      used_q  <= used_d;
      afull_q <= (used_d >= CNT_AF);
    end
  end

endmodule

// File: tb/tb_srl_shift_fifo.sv
// Self-checking bench for srl_shift_fifo against a queue-based reference.
// Latency: the model updates on each rising edge; outputs are compared on the falling edge.
// Backpressure: model accepts a push only below depth and a pop only when non-empty.
module tb_srl_shift_fifo;

  localparam int W  = 8;
  localparam int DL = 4;
  localparam int D  = 16;
  localparam int AF = 14;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [DL:0]   used;
  logic          afull;

  srl_shift_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .AFULL_LEVEL(AF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .used      (used),
    .afull     (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: words in arrival order, oldest at index 0.
  logic [W-1:0] q [$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/used"},      32'(used),      32'(q.size()));
    chk({tag, "/in_ready"},  32'(in_ready),  32'(q.size() < D));
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "/afull"},     32'(afull),     32'(q.size() >= AF));
    if (q.size() > 0) chk({tag, "/out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs,
  // then advance the model with the same inputs at the rising edge.
  task automatic step(input string tag, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic r);
    logic mp;
    logic mo;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    rst       = r;
    #1;
    check_outputs(tag);
    mp = iv && (q.size() < D);
    mo = ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (mo) void'(q.pop_front());
      if (mp) q.push_back(id);
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state (rst still high)
    check_outputs("reset");

    // Fill 0x00..0x0F with no reads, then offer a 17th word
    for (int i = 0; i < D; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    step("over", 1'b1, 8'hEE, 1'b0, 1'b0);
    step("over2", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain in order
    for (int i = 0; i < D; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drained", 1'b0, 8'h00, 1'b0, 1'b0);

    // Empty boundary: push and pop offered together, only the push happens
    step("empty_pp", 1'b1, 8'h3C, 1'b1, 1'b0);
    step("empty_vis", 1'b0, 8'h00, 1'b0, 1'b0);

    // Refill to full, then full boundary: pop only, then both
    for (int i = 0; i < D - 1; i++) step("refill", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    step("full_pp", 1'b1, 8'h77, 1'b1, 1'b0);
    step("f15_pp", 1'b1, 8'h78, 1'b1, 1'b0);
    step("f15_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain down to 5, then 20 simultaneous push/pop cycles
    for (int i = 0; i < 10; i++) step("to5", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("sim", 1'b1, W'(8'h90 + i), 1'b1, 1'b0);
    step("sim_end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Go to 9 words, then reset with in_valid held high
    for (int i = 0; i < 4; i++) step("to9", 1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    step("rst_mid", 1'b1, 8'h11, 1'b1, 1'b1);
    step("after_rst", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("a5_read", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           W'($urandom),
           1'($urandom_range(0, 2) != 0) ^ (i[7] & 1'($urandom_range(0, 1))),
           1'($urandom_range(0, 99) == 0));
    end
    step("final", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
